// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
// Shares the single register-file write port between the in-order WB stage
// and a long-latency unit (multiplier/divider). WB normally owns the port;
// LU results queue in a small FIFO and drain in idle slots. A starvation
// counter can stall WB for one cycle to let the FIFO head drain. pend_mask
// tells ID which registers still have a buffered LU result in flight.
module rf_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [37:0]                   wb_rf_zip,
  output logic                          wb_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_waddr,
  input  logic [31:0]                   lu_wdata,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic [31:0]                   pend_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SC_W   = $clog2(STARVE_LIMIT + 1);

  // Starvation counter advance that sticks once the forcing threshold is hit.
  function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] c);
    if (c == SC_W'(STARVE_LIMIT)) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  // Ring offset of a slot from the read pointer; wraps because depth is 2^n.
  function automatic logic [PTR_W-1:0] ring_off(input logic [PTR_W-1:0] idx,
                                                input logic [PTR_W-1:0] base);
    return idx - base;
  endfunction

  // WB request fields
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_req;

  // FIFO control state
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [SC_W-1:0]   starve_cnt;

  // FIFO payload (not reset: liveness is defined by the pointers/count)
  logic [ADDR_W-1:0] ent_waddr [FIFO_DEPTH];
  logic [DATA_W-1:0] ent_wdata [FIFO_DEPTH];

  logic              head_req;
  logic              starve_hit;
  logic              grant_head;
  logic              grant_wb;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_waddr;
  logic [DATA_W-1:0] head_wdata;

  assign wb_we    = wb_rf_zip[37];
  assign wb_waddr = wb_rf_zip[36:32];
  assign wb_wdata = wb_rf_zip[31:0];

  // A write to r0 never contends for the port.
  assign wb_req   = wb_we & (wb_waddr != '0);

  assign head_req   = (cnt != '0);
  assign head_waddr = ent_waddr[rd_ptr];
  assign head_wdata = ent_wdata[rd_ptr];

  // The head wins either because it has waited long enough, or because WB is idle.
  assign starve_hit = head_req & (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant_head = starve_hit | (head_req & ~wb_req);
  assign grant_wb   = wb_req & ~starve_hit;

  // Acceptance depends on occupancy alone so LU never sees a pop-dependent path.
  assign fifo_full = (cnt == CNT_W'(FIFO_DEPTH));
  assign push      = lu_valid & ~fifo_full;
  assign pop       = grant_head;

  assign lu_ready  = resetn & ~fifo_full;
  assign wb_stall  = resetn & starve_hit & wb_req;
  assign fifo_cnt  = cnt;

  // Write-port mux; forced quiet while reset is asserted.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (resetn) begin
      if (grant_head) begin
        // An r0 entry is still popped, just not written.
        rf_we    = (head_waddr != '0);
        rf_waddr = head_waddr;
        rf_wdata = head_wdata;
      end else if (grant_wb) begin
        rf_we    = 1'b1;
        rf_waddr = wb_waddr;
        rf_wdata = wb_wdata;
      end
    end
  end

  // Pointer and occupancy tracking; push and pop in one cycle leave cnt unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Count cycles the head is denied; any pop or an empty FIFO restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (pop || !head_req) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_sat_inc(starve_cnt);
    end
  end

  // Capture LU result payload into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_waddr[wr_ptr] <= lu_waddr;
      ent_wdata[wr_ptr] <= lu_wdata;
    end
  end

  // Pending mask from registered state: one bit per live entry's target register.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ({1'b0, ring_off(PTR_W'(i), rd_ptr)} < cnt) begin
        pend_mask[ent_waddr[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Testbench for rf_wport_arbiter: directed steps from the test plan followed by
// a randomized phase, every cycle compared against a queue-based model.
module tb_rf_wport_arbiter;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;

  logic          clk;
  logic          resetn;
  logic [37:0]   wb_rf_zip;
  logic          wb_stall;
  logic          lu_valid;
  logic          lu_ready;
  logic [4:0]    lu_waddr;
  logic [31:0]   lu_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   pend_mask;
  logic [CW-1:0] fifo_cnt;

  rf_wport_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wb_rf_zip (wb_rf_zip),
    .wb_stall  (wb_stall),
    .lu_valid  (lu_valid),
    .lu_ready  (lu_ready),
    .lu_waddr  (lu_waddr),
    .lu_wdata  (lu_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask),
    .fifo_cnt  (fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: buffered LU results in arrival order plus a denial count.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];
  int   mstarve = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit m_wbreq();
    return (wb_rf_zip[37] == 1'b1) && (wb_rf_zip[36:32] != 5'd0);
  endfunction

  function automatic bit m_forced();
    return (mq.size() != 0) && (mstarve == STARVE_LIMIT);
  endfunction

  function automatic bit m_grant_head();
    return m_forced() || ((mq.size() != 0) && !m_wbreq());
  endfunction

  task automatic check_all(input string tag);
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic [31:0] exp_pm;
    exp_we = 1'b0;
    exp_a  = 5'd0;
    exp_d  = 32'd0;
    if (m_grant_head()) begin
      exp_we = (mq[0].a != 5'd0);
      exp_a  = mq[0].a;
      exp_d  = mq[0].d;
    end else if (m_wbreq()) begin
      exp_we = 1'b1;
      exp_a  = wb_rf_zip[36:32];
      exp_d  = wb_rf_zip[31:0];
    end
    exp_pm = 32'd0;
    foreach (mq[i]) begin
      if (mq[i].a != 5'd0) exp_pm[mq[i].a] = 1'b1;
    end
    chk({tag, ".rf_we"},    64'(rf_we),     64'(exp_we));
    chk({tag, ".rf_waddr"}, 64'(rf_waddr),  64'(exp_a));
    chk({tag, ".rf_wdata"}, 64'(rf_wdata),  64'(exp_d));
    chk({tag, ".wb_stall"}, 64'(wb_stall),  64'(m_forced() && m_wbreq()));
    chk({tag, ".lu_ready"}, 64'(lu_ready),  64'(mq.size() < FIFO_DEPTH));
    chk({tag, ".pend"},     64'(pend_mask), 64'(exp_pm));
    chk({tag, ".cnt"},      64'(fifo_cnt),  64'(mq.size()));
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_edge();
    bit   gh;
    bit   pu;
    int   n;
    ent_t e;
    n  = mq.size();
    gh = m_grant_head();
    pu = lu_valid && (n < FIFO_DEPTH);
    if (gh) void'(mq.pop_front());
    if (gh || n == 0) mstarve = 0;
    else if (mstarve < STARVE_LIMIT) mstarve++;
    if (pu) begin
      e.a = lu_waddr;
      e.d = lu_wdata;
      mq.push_back(e);
    end
  endtask

  // Phase helpers: inputs are driven at posedge+1, outputs sampled at posedge+5.
  task automatic half();
    #4;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cyc(input string tag);
    half();
    check_all(tag);
    edge_step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    bit          prev_st;
    bit          st;
    bit          lu_acc;
    int          stalls;
    int          busy_pct;
    logic [31:0] wbd;
    logic [31:0] held;

    resetn    = 1'b0;
    wb_rf_zip = '0;
    lu_valid  = 1'b0;
    lu_waddr  = '0;
    lu_wdata  = '0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rf_we",    64'(rf_we),     64'(0));
    chk("rst.wb_stall", 64'(wb_stall),  64'(0));
    chk("rst.cnt",      64'(fifo_cnt),  64'(0));
    chk("rst.pend",     64'(pend_mask), 64'(0));
    resetn = 1'b1;
    mq.delete();
    mstarve = 0;

    // Idle after release
    half();
    chk("idle.rf_we",    64'(rf_we),     64'(0));
    chk("idle.wb_stall", 64'(wb_stall),  64'(0));
    chk("idle.lu_ready", 64'(lu_ready),  64'(1));
    chk("idle.cnt",      64'(fifo_cnt),  64'(0));
    chk("idle.pend",     64'(pend_mask), 64'(0));
    check_all("idle");
    edge_step();
    cyc("idle2");

    // WB only, then a WB write to r0
    wb_rf_zip = {1'b1, 5'd3, 32'h0000_1234};
    half();
    chk("wb3.rf_we",    64'(rf_we),    64'(1));
    chk("wb3.rf_waddr", 64'(rf_waddr), 64'(3));
    chk("wb3.rf_wdata", 64'(rf_wdata), 64'(32'h1234));
    check_all("wb3");
    edge_step();
    wb_rf_zip = {1'b1, 5'd0, 32'h0000_FFFF};
    half();
    chk("wb0.rf_we", 64'(rf_we), 64'(0));
    check_all("wb0");
    edge_step();
    wb_rf_zip = '0;

    // LU push into an idle port: no bypass, written the next cycle
    lu_valid = 1'b1;
    lu_waddr = 5'd7;
    lu_wdata = 32'hA5A5_A5A5;
    half();
    chk("lu7.nobypass", 64'(rf_we), 64'(0));
    check_all("lu7.push");
    edge_step();
    lu_valid = 1'b0;
    half();
    chk("lu7.pend7",    64'(pend_mask[7]), 64'(1));
    chk("lu7.rf_we",    64'(rf_we),        64'(1));
    chk("lu7.rf_waddr", 64'(rf_waddr),     64'(7));
    chk("lu7.rf_wdata", 64'(rf_wdata),     64'(32'hA5A5_A5A5));
    check_all("lu7.pop");
    edge_step();
    half();
    chk("lu7.pend_clr", 64'(pend_mask), 64'(0));
    chk("lu7.cnt0",     64'(fifo_cnt),  64'(0));
    check_all("lu7.after");
    edge_step();

    // FIFO full back-pressure under continuous WB traffic
    wb_rf_zip = {1'b1, 5'd1, 32'h0000_0100};
    lu_valid  = 1'b1;
    lu_waddr  = 5'd8;
    lu_wdata  = 32'h0000_8888;
    cyc("full.p8");
    lu_waddr  = 5'd9;
    lu_wdata  = 32'h0000_9999;
    cyc("full.p9");
    lu_waddr  = 5'd10;
    lu_wdata  = 32'h0000_AAAA;
    half();
    chk("full.lu_ready", 64'(lu_ready),  64'(0));
    chk("full.cnt",      64'(fifo_cnt),  64'(2));
    chk("full.pend",     64'(pend_mask), 64'(32'h0000_0300));
    check_all("full.first");
    edge_step();
    acc = 1'b0;
    for (int k = 0; k < 12 && !acc; k++) begin
      half();
      acc = lu_ready;
      check_all("full.hold");
      edge_step();
    end
    chk("full.accept", 64'(acc), 64'(1));
    lu_valid  = 1'b0;
    wb_rf_zip = '0;
    repeat (4) cyc("full.drain");

    // Starvation: WB busy every cycle, one LU entry must be forced through
    wbd       = 32'h0000_5000;
    wb_rf_zip = {1'b1, 5'd2, wbd};
    lu_valid  = 1'b1;
    lu_waddr  = 5'd12;
    lu_wdata  = 32'hC0DE_0012;
    cyc("stv.push");
    lu_valid = 1'b0;
    prev_st  = 1'b0;
    stalls   = 0;
    held     = 32'd0;
    for (int k = 1; k <= STARVE_LIMIT + 2; k++) begin
      if (!prev_st) begin
        wbd       = wbd + 32'd1;
        wb_rf_zip = {1'b1, 5'd2, wbd};
      end
      half();
      prev_st = wb_stall;
      if (wb_stall) stalls++;
      if (k == STARVE_LIMIT + 1) begin
        chk("stv.stall",    64'(wb_stall), 64'(1));
        chk("stv.lu_addr",  64'(rf_waddr), 64'(12));
        chk("stv.lu_data",  64'(rf_wdata), 64'(32'hC0DE_0012));
        held = wbd;
      end else begin
        chk("stv.nostall",  64'(wb_stall), 64'(0));
        chk("stv.wb_we",    64'(rf_we),    64'(1));
        chk("stv.wb_addr",  64'(rf_waddr), 64'(2));
      end
      if (k == STARVE_LIMIT + 2) begin
        chk("stv.wb_held", 64'(rf_wdata), 64'(held));
      end
      check_all("stv");
      edge_step();
    end
    chk("stv.stall_count", 64'(stalls), 64'(1));
    wb_rf_zip = '0;
    repeat (2) cyc("stv.idle");

    // Asynchronous reset while two entries are draining
    wb_rf_zip = {1'b1, 5'd1, 32'h0000_0111};
    lu_valid  = 1'b1;
    lu_waddr  = 5'd20;
    lu_wdata  = 32'h0000_2020;
    cyc("arst.p20");
    lu_waddr  = 5'd21;
    lu_wdata  = 32'h0000_2121;
    cyc("arst.p21");
    lu_valid  = 1'b0;
    wb_rf_zip = '0;
    #1;
    chk("arst.pre_we",   64'(rf_we),    64'(1));
    chk("arst.pre_addr", 64'(rf_waddr), 64'(20));
    chk("arst.pre_cnt",  64'(fifo_cnt), 64'(2));
    resetn = 1'b0;
    #1;
    chk("arst.cnt",   64'(fifo_cnt),  64'(0));
    chk("arst.pend",  64'(pend_mask), 64'(0));
    chk("arst.rf_we", 64'(rf_we),     64'(0));
    mq.delete();
    mstarve = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("arst.post_we", 64'(rf_we), 64'(0));
      check_all("arst.post");
      edge_step();
    end

    // Randomized traffic, WB holding while stalled and LU holding until accepted
    for (int c = 0; c < 600; c++) begin
      busy_pct = (c < 300) ? 70 : 95;
      half();
      st     = wb_stall;
      lu_acc = lu_valid && lu_ready;
      check_all("rnd");
      edge_step();
      if (!st) begin
        wb_rf_zip = {($urandom_range(0, 99) < busy_pct) ? 1'b1 : 1'b0,
                     5'($urandom_range(0, 31)), 32'($urandom())};
      end
      if (!lu_valid || lu_acc) begin
        lu_valid = ($urandom_range(0, 9) < 4);
        lu_waddr = 5'($urandom_range(0, 7));
        lu_wdata = 32'($urandom());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
